// File: rtl/vga_console_term_if.sv
// vga_console_term_if: host character channel, text-buffer port and cursor/status
// signals of the console terminal.
//   slave  : the terminal itself (consumes characters, drives the buffer port)
//   master : the environment (host + text buffer)
interface vga_console_term_if;
    logic       in_valid;
    logic [8:0] in_data;      // [8:7] colour index, [6:0] ASCII code
    logic       in_ready;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_rd_addr;
    logic [8:0] buf_rd_data;  // combinational read data from the text buffer
    logic [3:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;

    modport slave (
        input  in_valid, in_data, buf_rd_data,
        output in_ready, buf_we, buf_addr, buf_wdata, buf_rd_addr,
               cursor_col, cursor_row, busy
    );

    modport master (
        output in_valid, in_data, buf_rd_data,
        input  in_ready, buf_we, buf_addr, buf_wdata, buf_rd_addr,
               cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/vga_console_term.sv
// vga_console_term: character-stream console writing into a text buffer.
// Handles printable characters, LF, CR, BS and FF; overflow past the last row
// either scrolls (VGA_CONSOLE_TERM_SCROLL_EN defined) or wraps to row 0 and
// clears it (default).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : vga_console_term_if.slave (host channel, buffer port, cursor, busy)
module vga_console_term #(
    parameter int unsigned NUM_ROWS = 3,
    parameter int unsigned NUM_COLS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_console_term_if.slave     bus
);
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 2;
    localparam int unsigned DW = 9;

    localparam logic [AW-1:0] LAST_CELL = AW'(NUM_ROWS*NUM_COLS - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(NUM_COLS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(NUM_ROWS - 1);
    localparam logic [DW-1:0] BLANK     = DW'(9'h020);
`ifdef VGA_CONSOLE_TERM_SCROLL_EN
    localparam logic [AW-1:0] COPY_LAST     = AW'((NUM_ROWS-1)*NUM_COLS - 1);
    localparam logic [AW-1:0] LAST_ROW_BASE = AW'((NUM_ROWS-1)*NUM_COLS);
`else
    localparam logic [AW-1:0] ROW0_LAST     = AW'(NUM_COLS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR
`ifdef VGA_CONSOLE_TERM_SCROLL_EN
        , S_SCROLL
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   cnt_q, cnt_d;        // current cell during SCROLL/CLEAR
    logic [AW-1:0]   clr_end_q, clr_end_d; // last cell of the active CLEAR range
    logic [DW-1:0]   data_q, data_d;
    logic            adv_q, adv_d;         // WRITE advances the cursor (not for BS)

    logic [6:0]      code;
    logic            overflow;
    logic [AW-1:0]   cursor_addr;

    assign code        = bus.in_data[6:0];
    assign cursor_addr = AW'(row_q) * AW'(NUM_COLS) + AW'(col_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            clr_end_q <= '0;
            data_q    <= '0;
            adv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            clr_end_q <= clr_end_d;
            data_q    <= data_d;
            adv_q     <= adv_d;
        end
    end

    // Next-state and cursor logic
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        clr_end_d = clr_end_q;
        data_d    = data_q;
        adv_d     = adv_q;
        overflow  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (code >= 7'h20 && code <= 7'h7E) begin
                        data_d  = bus.in_data;
                        adv_d   = 1'b1;
                        state_d = S_WRITE;
                    end else if (code == 7'h0A) begin
                        col_d = '0;
                        if (row_q == ROW_MAX) overflow = 1'b1;
                        else                  row_d = row_q + RW'(1);
                    end else if (code == 7'h0D) begin
                        col_d = '0;
                    end else if (code == 7'h08) begin
                        if (col_q != '0) begin
                            col_d   = col_q - CW'(1);
                            data_d  = BLANK;
                            adv_d   = 1'b0;
                            state_d = S_WRITE;
                        end
                    end else if (code == 7'h0C) begin
                        col_d     = '0;
                        row_d     = '0;
                        cnt_d     = '0;
                        clr_end_d = LAST_CELL;
                        state_d   = S_CLEAR;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (adv_q) begin
                    if (col_q < COL_MAX) begin
                        col_d = col_q + CW'(1);
                    end else begin
                        col_d = '0;
                        if (row_q == ROW_MAX) overflow = 1'b1;
                        else                  row_d = row_q + RW'(1);
                    end
                end
            end
`ifdef VGA_CONSOLE_TERM_SCROLL_EN
            S_SCROLL: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == COPY_LAST) begin
                    cnt_d     = LAST_ROW_BASE;
                    clr_end_d = LAST_CELL;
                    state_d   = S_CLEAR;
                end
            end
`endif
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == clr_end_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Overflow past the last row: scroll up, or wrap to row 0 and blank it
        if (overflow) begin
`ifdef VGA_CONSOLE_TERM_SCROLL_EN
            row_d   = ROW_MAX;
            cnt_d   = '0;
            state_d = S_SCROLL;
`else
            row_d     = '0;
            cnt_d     = '0;
            clr_end_d = ROW0_LAST;
            state_d   = S_CLEAR;
`endif
        end
    end

    // Buffer port and status, decoded from registered state
    always_comb begin
        bus.in_ready    = (state_q == S_IDLE);
        bus.busy        = (state_q != S_IDLE);
        bus.buf_we      = 1'b0;
        bus.buf_addr    = '0;
        bus.buf_wdata   = '0;
        bus.buf_rd_addr = '0;
        bus.cursor_col  = col_q;
        bus.cursor_row  = row_q;
        case (state_q)
            S_WRITE: begin
                bus.buf_we    = 1'b1;
                bus.buf_addr  = cursor_addr;
                bus.buf_wdata = data_q;
            end
`ifdef VGA_CONSOLE_TERM_SCROLL_EN
            S_SCROLL: begin
                bus.buf_we      = 1'b1;
                bus.buf_addr    = cnt_q;
                bus.buf_rd_addr = cnt_q + AW'(NUM_COLS);
                bus.buf_wdata   = bus.buf_rd_data;
            end
`endif
            S_CLEAR: begin
                bus.buf_we    = 1'b1;
                bus.buf_addr  = cnt_q;
                bus.buf_wdata = BLANK;
            end
            default: ;
        endcase
    end
endmodule
